// File: rtl/nios_system_gpio_port.sv
// nios_system_gpio_port
//   Avalon-MM slave GPIO port with WIDTH bits. It provides:
//   - per-bit direction control
//   - atomic set and clear of the output register
//   - a three-stage input synchroniser
//   - sticky edge capture with write-one-to-clear
//   - a maskable level interrupt
//
// Ports
//   clk        system clock
//   reset      asynchronous active-high reset
//   address    word register select (0 DATA, 1 DIR, 2 IRQMASK, 3 EDGECAP,
//              4 OUTSET, 5 OUTCLR, 6/7 unused)
//   chipselect slave select
//   write_n    active-low write strobe (a write is chipselect & ~write_n)
//   writedata  write data; only bits [WIDTH-1:0] are used
//   readdata   combinational read data; bits above WIDTH read as zero
//   in_port    asynchronous pin inputs
//   out_port   output data register
//   oe         direction register (1 = drive pin)
//   irq        level interrupt, |(capture & mask)
module nios_system_gpio_port #(
  parameter int unsigned      WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_OUT = '0,
  parameter logic [WIDTH-1:0] RESET_DIR = '0,
  parameter int unsigned      EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic [WIDTH-1:0] oe,
  output logic             irq
);

  localparam logic [2:0] ADDR_DATA    = 3'd0;
  localparam logic [2:0] ADDR_DIR     = 3'd1;
  localparam logic [2:0] ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] ADDR_OUTSET  = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] s1_q, s2_q, s3_q;
  logic [WIDTH-1:0] edge_raw;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rd_word;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];
  // Upper writedata bits are ignored when WIDTH < 32.
  assign unused_wdata = &{1'b0, writedata};

  // s1 is the metastability stage. Edges are detected between s2 and s3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= in_port;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  generate
    if (EDGE_TYPE == 0) begin : g_rise
      assign edge_raw = s2_q & ~s3_q;
    end else if (EDGE_TYPE == 1) begin : g_fall
      assign edge_raw = ~s2_q & s3_q;
    end else begin : g_any
      assign edge_raw = s2_q ^ s3_q;
    end
  endgenerate

  // Only bits configured as inputs may capture.
  assign edge_det = edge_raw & ~dir_q;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    mask_d = mask_q;
    // A new edge wins over a simultaneous W1C of the same bit.
    cap_d  = cap_q | edge_det;
    if (wr_en) begin
      case (address)
        ADDR_DATA:    out_d  = wdata;
        ADDR_DIR:     dir_d  = wdata;
        ADDR_IRQMASK: mask_d = wdata;
        ADDR_EDGECAP: cap_d  = (cap_q & ~wdata) | edge_det;
        ADDR_OUTSET:  out_d  = out_q | wdata;
        ADDR_OUTCLR:  out_d  = out_q & ~wdata;
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q  <= RESET_OUT;
      dir_q  <= RESET_DIR;
      mask_q <= '0;
      cap_q  <= '0;
    end else begin
      out_q  <= out_d;
      dir_q  <= dir_d;
      mask_q <= mask_d;
      cap_q  <= cap_d;
    end
  end

  always_comb begin
    rd_word = '0;
    case (address)
      ADDR_DATA:    rd_word = (dir_q & out_q) | (~dir_q & s2_q);
      ADDR_DIR:     rd_word = dir_q;
      ADDR_IRQMASK: rd_word = mask_q;
      ADDR_EDGECAP: rd_word = cap_q;
      default:      rd_word = '0;
    endcase
    readdata = '0;
    readdata[WIDTH-1:0] = rd_word;
  end

  assign out_port = out_q;
  assign oe       = dir_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_nios_system_gpio_port.sv
// Directed testbench for nios_system_gpio_port. It uses three instances:
//   dut_a: 8 bits, rising-edge capture, non-zero reset values
//   dut_b: 8 bits, any-edge capture
//   dut_c: 32 bits, rising-edge capture
// All three instances share the bus.
module tb_nios_system_gpio_port;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [7:0]  in_ab;
  logic [31:0] in_c;
  logic [31:0] rd_a, rd_b, rd_c;
  logic [7:0]  out_a, oe_a, out_b, oe_b;
  logic [31:0] out_c, oe_c;
  logic        irq_a, irq_b, irq_c;

  int nvec = 0;
  int nmis = 0;

  always #5 clk = ~clk;

  assign in_c = {24'h0, in_ab};

  nios_system_gpio_port #(.WIDTH(8), .RESET_OUT(8'h3C), .RESET_DIR(8'h0F), .EDGE_TYPE(0)) dut_a (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_a),
    .in_port(in_ab), .out_port(out_a), .oe(oe_a), .irq(irq_a));

  nios_system_gpio_port #(.WIDTH(8), .EDGE_TYPE(2)) dut_b (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_b),
    .in_port(in_ab), .out_port(out_b), .oe(oe_b), .irq(irq_b));

  nios_system_gpio_port #(.WIDTH(32), .EDGE_TYPE(0)) dut_c (
    .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd_c),
    .in_port(in_c), .out_port(out_c), .oe(oe_c), .irq(irq_c));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input logic [2:0] a);
    @(negedge clk);
    address = a;
    #1;
  endtask

  task automatic settle();
    repeat (4) @(negedge clk);
  endtask

  logic [31:0] exp_a [8];

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 3'd0;
    writedata = '0; in_ab = 8'h00;
    exp_a = '{32'h0C, 32'h0F, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // 1: reset state of every register
    for (int i = 0; i < 8; i++) begin
      rd(3'(i));
      chk($sformatf("rst_a_reg%0d", i), rd_a, exp_a[i]);
      chk($sformatf("rst_b_reg%0d", i), rd_b, 32'h0);
    end
    chk("rst_out_a", {24'h0, out_a}, 32'h3C);
    chk("rst_irq_a", {31'h0, irq_a}, 32'h0);

    // 2: output writes and atomic set/clear
    wr(3'd1, 32'h1234_56FF);
    rd(3'd1);
    chk("dir_rd_upper0", rd_a, 32'hFF);
    wr(3'd0, 32'hA5);
    wr(3'd4, 32'h0A);
    wr(3'd5, 32'h81);
    chk("out_setclr", {24'h0, out_a}, 32'h2E);
    rd(3'd0);
    chk("data_rd_out", rd_a, 32'h2E);
    rd(3'd4);
    chk("outset_rd0", rd_a, 32'h0);

    // 3: rising capture latency, irq, W1C
    wr(3'd1, 32'h0);
    wr(3'd2, 32'h01);
    rd(3'd3);
    chk("cap_before", rd_a, 32'h0);
    @(negedge clk); in_ab = 8'h01;
    @(posedge clk); #1;
    chk("cap_k", rd_a, 32'h0);
    @(posedge clk); #1;
    chk("cap_k1", rd_a, 32'h0);
    address = 3'd0; #1;
    chk("data_k1", rd_a, 32'h01);
    address = 3'd3;
    @(posedge clk); #1;
    chk("cap_k2", rd_a, 32'h01);
    chk("irq_k2", {31'h0, irq_a}, 32'h1);
    wr(3'd3, 32'h01);
    chk("irq_w1c", {31'h0, irq_a}, 32'h0);
    rd(3'd3);
    chk("cap_w1c", rd_a, 32'h0);
    wr(3'd3, 32'hFF);

    // 4: falling edge on bit 3, rising-only versus any-edge
    @(negedge clk); in_ab = 8'h09;
    settle();
    rd(3'd3);
    chk("rise3_a", rd_a, 32'h08);
    wr(3'd3, 32'hFF);
    @(negedge clk); in_ab = 8'h01;
    settle();
    rd(3'd3);
    chk("fall3_a", rd_a, 32'h0);
    chk("fall3_b", rd_b, 32'h08);

    // 5: detect and W1C of the same bit in the same cycle
    @(negedge clk); in_ab = 8'h00;
    settle();
    @(negedge clk); in_ab = 8'h01;
    settle();
    rd(3'd3);
    chk("cap0_set", rd_a, 32'h01);
    @(negedge clk); in_ab = 8'h00;
    settle();
    @(negedge clk); in_ab = 8'h01;   // sampled at edge k
    @(negedge clk);                   // after edge k
    wr(3'd3, 32'h01);                 // write lands on edge k+2
    rd(3'd3);
    chk("cap_w1c_race", rd_a, 32'h01);
    chk("irq_w1c_race", {31'h0, irq_a}, 32'h1);

    // Mask change reaches irq one cycle after the write
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd2; writedata = 32'h0;
    #1;
    chk("irq_mask_pre", {31'h0, irq_a}, 32'h1);
    @(posedge clk); #1;
    chk("irq_mask_post", {31'h0, irq_a}, 32'h0);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    wr(3'd3, 32'hFF);

    // An output bit does not capture, and DATA reads the output register
    wr(3'd1, 32'h01);
    @(negedge clk); in_ab = 8'h00;
    settle();
    @(negedge clk); in_ab = 8'h01;
    settle();
    rd(3'd3);
    chk("dir_gate_cap", rd_a, 32'h0);
    rd(3'd0);
    chk("data_mux", rd_a, 32'h0);

    // 6: 32-bit instance, reset asserted mid-write
    @(negedge clk); in_ab = 8'h00;
    settle();
    wr(3'd0, 32'hFFFF_FFFF);
    wr(3'd1, 32'hFFFF_FFFF);
    chk("c_out_full", out_c, 32'hFFFF_FFFF);
    chk("c_oe_full", oe_c, 32'hFFFF_FFFF);
    rd(3'd0);
    chk("c_data_full", rd_c, 32'hFFFF_FFFF);
    chk("a_data_trunc", rd_a, 32'hFF);
    wr(3'd2, 32'hFFFF_FFFF);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = 3'd4; writedata = 32'h0;
    #2 reset = 1'b1;
    #1;
    chk("c_out_rst", out_c, 32'h0);
    chk("c_oe_rst", oe_c, 32'h0);
    chk("c_irq_rst", {31'h0, irq_c}, 32'h0);
    chk("a_out_rst", {24'h0, out_a}, 32'h3C);
    chk("a_oe_rst", {24'h0, oe_a}, 32'h0F);
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rd(3'(i));
      chk($sformatf("c_reg%0d_rst", i), rd_c, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
